// File: rtl/pong_defs.sv
// Shared Pong encodings: game states, play modes and player indices,
// used by the game controller, paddle and ball blocks.
package pong_defs;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_PP = 2'b00,
    MODE_PA = 2'b01,
    MODE_AP = 2'b10,
    MODE_AA = 2'b11
  } mode_t;

  localparam logic PLAYER0 = 1'b0;
  localparam logic PLAYER1 = 1'b1;

  // True when player p is driven by the AI in mode m.
  function automatic logic is_ai(input mode_t m, input logic p);
    return (m == MODE_PA && p == PLAYER1) ||
           (m == MODE_AP && p == PLAYER0) ||
           (m == MODE_AA);
  endfunction

endpackage

// File: rtl/pong_btn_edge.sv
// Registered rising-edge detector: evt is high on the first cycle a level
// input is seen high, so a held button produces exactly one event.
module pong_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= btn;
  end

  assign evt = btn & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game state, latched play mode, scores, serve ownership,
// AI auto-serve countdown and the one-cycle ball launch pulse.
module pong_game_ctrl
  import pong_defs::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_serve0,
  input  logic       btn_serve1,
  input  logic [1:0] mode_sel,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [1:0] state,
  output logic [1:0] mode,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       server,
  output logic       winner,
  output logic       launch,
  output logic       launch_dir
);

  localparam logic [3:0]       WIN_Q    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  logic start_evt, serve0_evt, serve1_evt;

  pong_btn_edge u_edge_start  (.clk(clk), .rst(rst), .btn(btn_start),  .evt(start_evt));
  pong_btn_edge u_edge_serve0 (.clk(clk), .rst(rst), .btn(btn_serve0), .evt(serve0_evt));
  pong_btn_edge u_edge_serve1 (.clk(clk), .rst(rst), .btn(btn_serve1), .evt(serve1_evt));

  state_t           state_r, state_n;
  mode_t            mode_r, mode_n;
  logic [3:0]       score0_r, score0_n, score1_r, score1_n;
  logic             server_r, server_n, winner_r, winner_n;
  logic             launch_r, launch_n, dir_r, dir_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_START;
      mode_r   <= MODE_PP;
      score0_r <= 4'd0;
      score1_r <= 4'd0;
      server_r <= PLAYER0;
      winner_r <= 1'b0;
      launch_r <= 1'b0;
      dir_r    <= 1'b1;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_n;
      mode_r   <= mode_n;
      score0_r <= score0_n;
      score1_r <= score1_n;
      server_r <= server_n;
      winner_r <= winner_n;
      launch_r <= launch_n;
      dir_r    <= dir_n;
      cnt_r    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    mode_n   = mode_r;
    score0_n = score0_r;
    score1_n = score1_r;
    server_n = server_r;
    winner_n = winner_r;
    launch_n = 1'b0;
    dir_n    = dir_r;
    cnt_n    = cnt_r;
    unique case (state_r)
      ST_START: begin
        if (start_evt) begin
          state_n  = ST_SERVE;
          mode_n   = mode_t'(mode_sel);
          score0_n = 4'd0;
          score1_n = 4'd0;
          server_n = PLAYER0;
          cnt_n    = '0;
        end
      end
      ST_SERVE: begin
        // AI servers launch on the countdown; humans on their own button only.
        if (is_ai(mode_r, server_r)) begin
          if (cnt_r == CNT_LAST) begin
            state_n  = ST_PLAY;
            cnt_n    = '0;
            launch_n = 1'b1;
            dir_n    = ~server_r;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end else if (server_r ? serve1_evt : serve0_evt) begin
          state_n  = ST_PLAY;
          launch_n = 1'b1;
          dir_n    = ~server_r;
        end
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          state_n = ST_SERVE;
          cnt_n   = '0;
        end else if (miss_left) begin
          score1_n = score1_r + 4'd1;
          server_n = PLAYER0;
          cnt_n    = '0;
          if (score1_r + 4'd1 == WIN_Q) begin
            state_n  = ST_DONE;
            winner_n = PLAYER1;
          end else begin
            state_n = ST_SERVE;
          end
        end else if (miss_right) begin
          score0_n = score0_r + 4'd1;
          server_n = PLAYER1;
          cnt_n    = '0;
          if (score0_r + 4'd1 == WIN_Q) begin
            state_n  = ST_DONE;
            winner_n = PLAYER0;
          end else begin
            state_n = ST_SERVE;
          end
        end
      end
      ST_DONE: begin
        if (start_evt) state_n = ST_START;
      end
      default: state_n = ST_START;
    endcase
  end

  assign state      = state_r;
  assign mode       = mode_r;
  assign score0     = score0_r;
  assign score1     = score1_r;
  assign server     = server_r;
  assign winner     = winner_r;
  assign launch     = launch_r;
  assign launch_dir = dir_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3 and SERVE_DELAY=8.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, btn_start, btn_serve0, btn_serve1, miss_left, miss_right;
  logic [1:0] mode_sel;
  logic [1:0] state, mode;
  logic [3:0] score0, score1;
  logic       server, winner, launch, launch_dir;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_serve0(btn_serve0),
    .btn_serve1(btn_serve1), .mode_sel(mode_sel), .miss_left(miss_left),
    .miss_right(miss_right), .state(state), .mode(mode), .score0(score0),
    .score1(score1), .server(server), .winner(winner), .launch(launch),
    .launch_dir(launch_dir)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_start = 0; btn_serve0 = 0; btn_serve1 = 0;
    miss_left = 0; miss_right = 0; mode_sel = 2'b00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic start_match(input logic [1:0] m);
    mode_sel = m; btn_start = 1'b1; tick();
    btn_start = 1'b0; mode_sel = 2'b00;
  endtask

  task automatic press_serve(input logic p);
    if (p) btn_serve1 = 1'b1; else btn_serve0 = 1'b1;
    tick();
    btn_serve0 = 1'b0; btn_serve1 = 1'b0;
  endtask

  task automatic miss(input logic l, input logic r);
    miss_left = l; miss_right = r; tick();
    miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    total++; if (score0 !== 4'd0 || score1 !== 4'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d want=0/0", score0, score1); end
    total++; if (server !== 1'b0 || winner !== 1'b0 || launch !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b want=000", server, winner, launch); end
    total++; if (launch_dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", launch_dir); end
  endtask

  task automatic test_start_hold();
    mode_sel = 2'b00; btn_start = 1'b1;
    tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL start_to_serve got=%0d want=1", state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL start_held_cyc%0d got=%0d want=1", i, state); end
    end
    btn_start = 1'b0;
    total++; if (mode !== 2'd0 || score0 !== 0 || score1 !== 0 || server !== 0) begin
      bad++; $display("FAIL start_init got mode=%0d sc=%0d/%0d srv=%b want 0 0/0 0", mode, score0, score1, server); end
  endtask

  task automatic test_pp_serve();
    press_serve(1'b1); tick();
    total++; if (state !== 2'd1 || launch !== 1'b0) begin bad++; $display("FAIL wrong_server got st=%0d l=%b want 1 0", state, launch); end
    press_serve(1'b0);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL serve_play got=%0d want=2", state); end
    total++; if (launch !== 1'b1 || launch_dir !== 1'b1) begin bad++; $display("FAIL serve_launch got l=%b d=%b want 1 1", launch, launch_dir); end
    tick();
    total++; if (launch !== 1'b0 || state !== 2'd2) begin bad++; $display("FAIL launch_one_cycle got l=%b st=%0d want 0 2", launch, state); end
  endtask

  task automatic test_simul_miss();
    miss(1'b1, 1'b1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL simul_state got=%0d want=1", state); end
    total++; if (score0 !== 0 || score1 !== 0 || server !== 0) begin bad++; $display("FAIL simul_scores got=%0d/%0d srv=%b want 0/0 0", score0, score1, server); end
  endtask

  task automatic aa_countdown(input string tag, input logic dir_exp);
    for (int i = 0; i < 7; i++) begin
      tick();
      total++; if (state !== 2'd1 || launch !== 1'b0) begin bad++; $display("FAIL %s_wait%0d got st=%0d l=%b want 1 0", tag, i, state, launch); end
    end
    tick();
    total++; if (state !== 2'd2 || launch !== 1'b1) begin bad++; $display("FAIL %s_launch got st=%0d l=%b want 2 1", tag, state, launch); end
    total++; if (launch_dir !== dir_exp) begin bad++; $display("FAIL %s_dir got=%b want=%b", tag, launch_dir, dir_exp); end
    tick();
    total++; if (launch !== 1'b0) begin bad++; $display("FAIL %s_pulse got=%b want=0", tag, launch); end
  endtask

  task automatic test_aa_autoserve();
    do_reset();
    start_match(2'b11);
    total++; if (mode !== 2'd3 || state !== 2'd1) begin bad++; $display("FAIL aa_enter got mode=%0d st=%0d want 3 1", mode, state); end
    aa_countdown("aa1", 1'b1);
    miss(1'b0, 1'b1);
    total++; if (score0 !== 4'd1 || server !== 1'b1 || state !== 2'd1) begin
      bad++; $display("FAIL aa_miss_right got sc0=%0d srv=%b st=%0d want 1 1 1", score0, server, state); end
    aa_countdown("aa2", 1'b0);
  endtask

  task automatic test_win_pa();
    do_reset();
    start_match(2'b01);
    for (int i = 0; i < 3; i++) begin
      press_serve(1'b0);
      miss(1'b1, 1'b0);
      total++; if (score1 !== 4'(i + 1)) begin bad++; $display("FAIL win_score%0d got=%0d want=%0d", i, score1, i + 1); end
    end
    total++; if (state !== 2'd3 || winner !== 1'b1) begin bad++; $display("FAIL win_done got st=%0d w=%b want 3 1", state, winner); end
    miss(1'b1, 1'b0); miss(1'b0, 1'b1);
    total++; if (score0 !== 0 || score1 !== 3 || state !== 2'd3) begin bad++; $display("FAIL done_hold got %0d/%0d st=%0d want 0/3 3", score0, score1, state); end
    btn_start = 1'b1; tick();
    total++; if (state !== 2'd0 || score1 !== 4'd3) begin bad++; $display("FAIL done_to_start got st=%0d sc1=%0d want 0 3", state, score1); end
    tick(); tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL no_chain got=%0d want=0", state); end
    btn_start = 1'b0; tick();
    start_match(2'b10);
    total++; if (state !== 2'd1 || score0 !== 0 || score1 !== 0 || mode !== 2'd2) begin
      bad++; $display("FAIL restart got st=%0d sc=%0d/%0d mode=%0d want 1 0/0 2", state, score0, score1, mode); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_match(2'b00);
    press_serve(1'b0); miss(1'b0, 1'b1);
    press_serve(1'b1); miss(1'b0, 1'b1);
    press_serve(1'b1); miss(1'b1, 1'b0);
    press_serve(1'b0);
    total++; if (state !== 2'd2 || score0 !== 2 || score1 !== 1) begin bad++; $display("FAIL pre_rst got st=%0d %0d/%0d want 2 2/1", state, score0, score1); end
    rst = 1'b1; miss_left = 1'b1; tick();
    rst = 1'b0; miss_left = 1'b0;
    total++; if (state !== 0 || score0 !== 0 || score1 !== 0 || server !== 0 || launch !== 0 || launch_dir !== 1 || mode !== 0) begin
      bad++; $display("FAIL rst_play got st=%0d %0d/%0d srv=%b l=%b d=%b want 0 0/0 0 0 1", state, score0, score1, server, launch, launch_dir); end
    start_match(2'b11);
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (state !== 0 || mode !== 0 || launch !== 0) begin bad++; $display("FAIL rst_serve got st=%0d mode=%0d l=%b want 0 0 0", state, mode, launch); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (launch !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL rst_quiet%0d got l=%b st=%0d want 0 0", i, launch, state); end
    end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_pp_serve();
    test_simul_miss();
    test_aa_autoserve();
    test_win_pa();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for Pong. It owns the 2-bit game state (START/SERVE/PLAY/DONE) and the latched 2-bit play mode (PP/PA/AP/AA) that drive both paddle blocks and the ball block. It tracks both scores and decides which player serves. It issues a one-cycle ball launch pulse and auto-serves for AI-controlled servers.

Parameters:
WIN_SCORE, 7, score that ends the match (1..15)
SERVE_DELAY, 25000000, clk cycles an AI server waits in SERVE before launching (>=1)
CNT_W, 25, width of serve-delay counter; must hold SERVE_DELAY

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_start  in  1  debounced start button, level
btn_serve0  in  1  debounced serve button, player 0 (left), level
btn_serve1  in  1  debounced serve button, player 1 (right), level
mode_sel  in  2  mode switches; 00 PP, 01 PA, 10 AP, 11 AA
miss_left  in  1  one-cycle pulse from ball block: ball passed player 0 paddle
miss_right  in  1  one-cycle pulse from ball block: ball passed player 1 paddle
state  out  2  00 START, 01 SERVE, 10 PLAY, 11 DONE
mode  out  2  mode latched at match start
score0  out  4  player 0 score
score1  out  4  player 1 score
server  out  1  player to serve next (0 left, 1 right)
winner  out  1  match winner; valid only in DONE
launch  out  1  one-cycle pulse on the SERVE->PLAY transition
launch_dir  out  1  ball direction for launch: 0 toward player 0, 1 toward player 1

Behaviour:
- Reset (rst=1 at posedge, dominates all inputs, any state): state=START, mode=PP, score0=score1=0, server=0, winner=0, launch=0, launch_dir=1, delay counter=0, button history regs=0.
- Buttons are edge-detected. The previous-cycle sample is registered. An event is in&~prev, and acts on that same posedge. Holding a button yields exactly one event.
- is_ai(p) = (mode==PA && p==1) || (mode==AP && p==0) || mode==AA.
- START: on btn_start event -> SERVE, mode<=mode_sel, scores<=0, server<=0, counter<=0. mode_sel is ignored in every other state.
- SERVE (human server): on serve event of the current server only -> PLAY. The other player's button is ignored.
- SERVE (AI server): counter increments each cycle. When counter==SERVE_DELAY-1 -> PLAY and counter<=0. Human buttons are ignored.
- SERVE->PLAY: launch=1 for exactly one cycle, registered and coincident with the first PLAY cycle. launch_dir<=~server, so the ball travels away from the server.
- PLAY, miss_left only: score1+1, server<=0 (the conceding player serves). If the new score1==WIN_SCORE -> DONE with winner=1; else -> SERVE with counter<=0.
- PLAY, miss_right only: mirror case. score0+1, server<=1, winner=0 on a win.
- PLAY, miss_left and miss_right in the same cycle: no score change, server unchanged, -> SERVE.
- PLAY, btn_start event: ignored. Miss pulses outside PLAY are ignored.
- DONE: scores, winner and mode hold. On btn_start event -> START, with scores still shown until the next START->SERVE.
- Scores never exceed WIN_SCORE and never wrap; the 4-bit width suffices.
- All outputs are registered; none is a combinational function of inputs.
- A single btn_start event moves exactly one state; it cannot chain DONE->START->SERVE.

Decomposition:
- Shared package/header pong_defs: state encodings START/SERVE/PLAY/DONE = 00/01/10/11, mode encodings PP/PA/AP/AA = 00/01/10/11, player indices. The same package is used by the paddle and ball blocks.
- One natural sub-module, pong_btn_edge: registered rising-edge detector, instantiated three times.
- The FSM, score and serve-delay logic stay in this module.

Test Plan:
- Reset then btn_start high for 5 cycles, mode_sel=00 -> state START->SERVE once, mode=00, scores 0/0, server=0.
- PP, SERVE, btn_serve1 pulse then btn_serve0 pulse -> no change on serve1; on serve0 state=PLAY, launch high exactly 1 cycle, launch_dir=1.
- AA with SERVE_DELAY=8: enter SERVE -> PLAY exactly 8 cycles later, with one launch pulse. miss_right -> score0=1, server=1, SERVE; after 8 more cycles launch_dir=0.
- WIN_SCORE=3, PA: three miss_left pulses with serves between -> score1=3, state=DONE, winner=1. Further miss pulses leave scores at 3. btn_start -> START with scores held; btn_start again -> SERVE with 0/0.
- Simultaneous miss_left and miss_right in PLAY -> scores unchanged, state=SERVE, server unchanged.
- rst asserted mid-PLAY with score 2/1 and mid-SERVE countdown -> next cycle all outputs at reset values; launch never pulses.
